// File: rtl/proc_pkg.sv
// Shared processor package: sequencer state encodings, phase encoding and
// default widths used by the clock stepping controller.
package proc_pkg;

    // Default width of the step-count request.
    localparam int PROC_CNT_W = 8;
    // Default width of the retired-cycle counter.
    localparam int PROC_CYC_W = 16;

    // Sequencer states of the clock stepping controller.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        FINISH = 2'd3
    } stepState_t;

    // Which half of the processor cycle is currently being driven.
    typedef enum logic {
        PH0 = 1'b0,
        PH1 = 1'b1
    } phase_t;

    // True when a halt/run-drop request asks the running sequence to stop.
    function automatic logic stopRequested(input logic run, input logic halt);
        return halt | ~run;
    endfunction

endpackage

// File: rtl/clock_step_ctrl.sv
// Clock stepping controller: turns run/halt/step requests into a stream of
// two-phase processor cycles (ph0 then ph1), counts retired cycles and
// signals completion of step or halted-run sequences.
module clock_step_ctrl
    import proc_pkg::*;
#(
    parameter int CNT_W = PROC_CNT_W,
    parameter int CYC_W = PROC_CYC_W
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    input  logic [CNT_W-1:0] stepCount,
    output logic             ph0,
    output logic             ph1,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycleCount
);

    stepState_t       stateReg;
    phase_t           phaseReg;
    logic [CNT_W-1:0] remainingReg;
    logic             ph0Reg;
    logic             ph1Reg;
    logic             busyReg;
    logic             doneReg;
    logic [CYC_W-1:0] cycleCountReg;
    logic             stopReq;

    // A running sequence winds down when halt is raised or run is dropped.
    assign stopReq = stopRequested(run, halt);

    // Sequencer, phase toggle, remaining-cycle counter and retired-cycle counter.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            stateReg      <= IDLE;
            phaseReg      <= PH0;
            remainingReg  <= '0;
            ph0Reg        <= 1'b0;
            ph1Reg        <= 1'b0;
            busyReg       <= 1'b0;
            doneReg       <= 1'b0;
            cycleCountReg <= '0;
        end else begin
            // Strobes and done are single-cycle pulses unless re-asserted below.
            ph0Reg  <= 1'b0;
            ph1Reg  <= 1'b0;
            doneReg <= 1'b0;

            // A processor cycle retires once its ph1 half has been driven.
            if (ph1Reg) begin
                cycleCountReg <= cycleCountReg + CYC_W'(1);
            end

            case (stateReg)
                IDLE: begin
                    phaseReg <= PH0;
                    if (halt) begin
                        // Halt has top priority: nothing starts.
                        stateReg <= IDLE;
                    end else if (step) begin
                        if (stepCount != '0) begin
                            stateReg     <= STEP;
                            remainingReg <= stepCount;
                            ph0Reg       <= 1'b1;
                            busyReg      <= 1'b1;
                        end else begin
                            // A zero-length step completes immediately.
                            doneReg <= 1'b1;
                        end
                    end else if (run) begin
                        stateReg <= RUN;
                        ph0Reg   <= 1'b1;
                        busyReg  <= 1'b1;
                    end
                end

                RUN: begin
                    if (phaseReg == PH0) begin
                        // The ph1 half is always issued once ph0 went out.
                        ph1Reg   <= 1'b1;
                        phaseReg <= PH1;
                        if (stopReq) begin
                            stateReg <= FINISH;
                        end
                    end else if (stopReq) begin
                        stateReg <= IDLE;
                        phaseReg <= PH0;
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                    end else begin
                        ph0Reg   <= 1'b1;
                        phaseReg <= PH0;
                    end
                end

                STEP: begin
                    if (phaseReg == PH0) begin
                        ph1Reg   <= 1'b1;
                        phaseReg <= PH1;
                        if (halt) begin
                            stateReg <= FINISH;
                        end
                    end else begin
                        remainingReg <= remainingReg - CNT_W'(1);
                        if ((remainingReg == CNT_W'(1)) || halt) begin
                            stateReg     <= IDLE;
                            phaseReg     <= PH0;
                            remainingReg <= '0;
                            busyReg      <= 1'b0;
                            doneReg      <= 1'b1;
                        end else begin
                            ph0Reg   <= 1'b1;
                            phaseReg <= PH0;
                        end
                    end
                end

                FINISH: begin
                    // The pending ph1 is on the outputs now; wrap up.
                    stateReg     <= IDLE;
                    phaseReg     <= PH0;
                    remainingReg <= '0;
                    busyReg      <= 1'b0;
                    doneReg      <= 1'b1;
                end

                default: begin
                    stateReg <= IDLE;
                    phaseReg <= PH0;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign ph0        = ph0Reg;
    assign ph1        = ph1Reg;
    assign busy       = busyReg;
    assign done       = doneReg;
    assign cycleCount = cycleCountReg;

endmodule

// File: doc/clock_step_ctrl.md
CLOCK_STEP_CTRL -- requirements
Module: clock_step_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the step-count request.
REQ-002 Parameter CYC_W, default 16: width of the retired-cycle counter.
REQ-003 clkIn  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clkIn.
REQ-005 run  input  1  level request to run continuously.
REQ-006 halt  input  1  level request to stop at the next processor-cycle boundary.
REQ-007 step  input  1  one-cycle pulse requesting stepCount processor cycles.
REQ-008 stepCount  input  CNT_W  number of processor cycles to issue, captured with step.
REQ-009 ph0  output  1  one-clkIn-cycle strobe: first half (read phase) of a processor cycle.
REQ-010 ph1  output  1  one-clkIn-cycle strobe: second half (write phase) of a processor cycle.
REQ-011 busy  output  1  high while in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse when a STEP or halted RUN sequence has ended.
REQ-013 cycleCount  output  CYC_W  processor cycles retired since reset.

Function
REQ-014 One processor cycle SHALL be exactly two clkIn cycles: ph0 in the first, ph1 in the second; ph0 and ph1 never high together.
REQ-015 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-016 States SHALL be IDLE, RUN, STEP, FINISH; a phase bit tracks ph0/ph1 within RUN, STEP and FINISH.
REQ-017 IDLE: with halt high, stay IDLE; else step with stepCount != 0 -> STEP; else run -> RUN; priority halt > step > run.
REQ-018 step with stepCount == 0 in IDLE SHALL stay IDLE, issue no strobes, and pulse done on the next cycle.
REQ-019 Latency: request sampled at edge t -> ph0 high during cycle t+1, ph1 during t+2.
REQ-020 RUN: issue ph0/ph1 alternately without gaps while run high and halt low.
REQ-021 RUN with halt high or run low: if sampled during a ph0 cycle -> FINISH (issue the pending ph1), then IDLE; if sampled during a ph1 cycle -> IDLE directly; done pulses in the cycle after the final ph1.
REQ-022 STEP: remaining counter loaded with stepCount, decremented on each ph1; after the ph1 that reaches zero -> IDLE with done pulsed in the next cycle.
REQ-023 halt in STEP SHALL behave as REQ-021 (current processor cycle always completes, never a lone ph0).
REQ-024 step pulses while busy SHALL be ignored; run is ignored in STEP.
REQ-025 cycleCount SHALL increment by one in the cycle after each ph1 and wrap from 2^CYC_W-1 to 0.
REQ-026 stepCount = 2^CNT_W-1 SHALL issue exactly that many processor cycles, no overflow of the remaining counter.

Reset
REQ-027 reset SHALL force state IDLE, phase ph0, remaining = 0, cycleCount = 0, ph0 = ph1 = busy = done = 0.
REQ-028 reset mid-cycle SHALL abandon any pending ph1 with no done pulse; reset overrides all inputs in the same cycle.

Structure
REQ-029 State encodings and default CNT_W/CYC_W SHALL live in the shared processor package (proc_pkg).
REQ-030 Single module; no sub-module required (phase toggle and counters are inline).

Verification
REQ-031 reset, then run=1 at edge 0 -> ph0 at cycles 1,3,5..., ph1 at 2,4,6...; cycleCount = 3 after cycle 6.
REQ-032 step pulse with stepCount=3 -> exactly 3 ph0/ph1 pairs in cycles 1-6, done high in cycle 7 only, busy low from cycle 7.
REQ-033 running, halt raised during a ph0 cycle -> one more ph1, then no strobes; done pulses once.
REQ-034 step with stepCount=0 -> no strobes, done one cycle later, cycleCount unchanged.
REQ-035 step and run and halt together in IDLE -> stays IDLE, no strobes; step+run only -> STEP taken.
REQ-036 CYC_W=4, run for 17 processor cycles -> cycleCount wraps 15->0 and reads 1; reset mid-STEP after a ph0 -> no ph1, all outputs 0 next cycle.
